cmd_parser_gen: RTL and testbench

- Parametrised successor command parser for the md5 search engine.
- Receives a byte stream from the rx front end, decodes commands, streams payload to the char_buff/md5 datapath and returns results through the byte transmitter.
- Widths are parametrised: target hash, byte counter and test countdown.
- Adds over the previous generation: an inter-byte receive timeout with abort, unknown-command detection, a STATUS command and a sticky error flag.

---
 rtl/cmd_parser_gen_if.sv | 50 +++++
 rtl/cmd_parser_gen.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cmd_parser_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_parser_gen_if.sv
// Purpose: host-side bundle between the rx/tx byte front ends, the md5 datapath and cmd_parser_gen.
// Latency: wires only, no storage.
// Backpressure: transmit is paced by txd_ready_next; receive has no backpressure, so every rxd strobe must be consumed.
interface cmd_parser_gen_if #(
  parameter int NUM_LEDS   = 8,
  parameter int HASH_BYTES = 16,
  parameter int CNT_BYTES  = 2
);
  logic [7:0]              rxd_data;
  logic                    rxd_data_ready;
  logic                    txd_ready_next;
  logic                    txd_start;
  logic [7:0]              txd_data;
  logic                    proc_done;
  logic                    proc_match;
  logic [8*CNT_BYTES-1:0]  proc_byte_pos;
  logic [7:0]              proc_match_char;
  logic                    proc_start;
  logic [8*CNT_BYTES-1:0]  proc_num_bytes;
  logic [7:0]              proc_data;
  logic                    proc_data_valid;
  logic                    proc_match_char_next;
  logic [8*HASH_BYTES-1:0] proc_target_hash;
  logic [15:0]             proc_str_len;
  logic                    cmd_done;
  logic                    cmd_match;
  logic                    cmd_error;
  logic                    desync;
  logic [NUM_LEDS-1:0]     led;

  // Parser side.
  modport slave (
    input  rxd_data, rxd_data_ready, txd_ready_next,
    input  proc_done, proc_match, proc_byte_pos, proc_match_char,
    output txd_start, txd_data,
    output proc_start, proc_num_bytes, proc_data, proc_data_valid, proc_match_char_next,
    output proc_target_hash, proc_str_len,
    output cmd_done, cmd_match, cmd_error, desync, led
  );

  // Host / environment side.
  modport master (
    output rxd_data, rxd_data_ready, txd_ready_next,
    output proc_done, proc_match, proc_byte_pos, proc_match_char,
    input  txd_start, txd_data,
    input  proc_start, proc_num_bytes, proc_data, proc_data_valid, proc_match_char_next,
    input  proc_target_hash, proc_str_len,
    input  cmd_done, cmd_match, cmd_error, desync, led
  );
endinterface

// File: rtl/cmd_parser_gen.sv
// Purpose: byte-stream command parser for the md5 search engine (hash/length setup, payload streaming, result return).
// Latency: payload/strobes registered one cycle after the rx strobe; txd_start/txd_data are same-cycle with txd_ready_next.
// Backpressure: transmit waits on txd_ready_next; receive states abort to IDLE after TIMEOUT_CYCLES idle clocks.
module cmd_parser_gen #(
  parameter int          NUM_LEDS       = 8,
  parameter int          HASH_BYTES     = 16,
  parameter int          CNT_BYTES      = 2,
  parameter int          TEST_COUNT     = 10,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [15:0] STR_LEN_RST    = 16'd152
) (
  input logic             clk,
  input logic             reset,
  cmd_parser_gen_if.slave bus
);

  localparam int HW = 8 * HASH_BYTES;
  localparam int PW = 8 * CNT_BYTES;
  // One counter serves every multi-byte phase; it must span the payload count and str_len>>3.
  localparam int CW = (PW > 16) ? PW : 16;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [7:0]    TEST_START = 8'(TEST_COUNT);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SET_HASH  = 4'd1,
    PROC_LEN  = 4'd2,
    PROC_DATA = 4'd3,
    PROC_WAIT = 4'd4,
    RET_POS   = 4'd5,
    RET_STR   = 4'd6,
    TEST      = 4'd7,
    STR_LEN   = 4'd8,
    STATUS    = 4'd9,
    ACK       = 4'd10
  } state_t;

  state_t state, next_state;

  logic [CW-1:0] byte_cnt;
  logic [CW-1:0] cnt_plus1;
  logic [TW-1:0] timer;

  // Shadows collect a field; the visible register only changes on the final byte.
  logic [HW-1:0] hash_shadow, target_hash_q;
  logic [PW-1:0] len_shadow, num_bytes_q;
  logic [15:0]   str_shadow, str_len_q;
  logic [HW-1:0] hash_shift;
  logic [PW-1:0] len_shift;
  logic [15:0]   str_shift;

  logic [7:0] proc_data_q;
  logic       proc_data_valid_q, proc_start_q;
  logic       cmd_match_q, cmd_error_q, desync_q, err_sticky;

  logic          in_rx, timeout_hit, rx_acc;
  logic          tx_go, mc_next, cnt_inc, last_byte, err_evt, desync_evt;
  logic [7:0]    tx_byte, pos_byte;
  logic [CW-1:0] str_bytes;
  logic [NUM_LEDS+3:0] led_ext;

  assign cnt_plus1 = byte_cnt + CW'(1);
  assign str_bytes = CW'(str_len_q[15:3]);

  // Concatenate-then-truncate keeps the shift legal for single-byte fields too.
  logic [HW+7:0] hash_cat;
  logic [PW+7:0] len_cat;
  logic [23:0]   str_cat;
  assign hash_cat   = {hash_shadow, bus.rxd_data};
  assign len_cat    = {len_shadow, bus.rxd_data};
  assign str_cat    = {str_shadow, bus.rxd_data};
  assign hash_shift = hash_cat[HW-1:0];
  assign len_shift  = len_cat[PW-1:0];
  assign str_shift  = str_cat[15:0];

  assign in_rx = (state == SET_HASH) || (state == PROC_LEN) ||
                 (state == PROC_DATA) || (state == STR_LEN);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_rx && (timer == TMR_LAST);
  assign rx_acc = in_rx && bus.rxd_data_ready && !timeout_hit;

  // Select the match-position byte for the current RET_POS step, MSB first.
  always_comb begin
    pos_byte = 8'h00;
    for (int i = 0; i < CNT_BYTES; i++) begin
      if (byte_cnt == CW'(i)) pos_byte = bus.proc_byte_pos[8*(CNT_BYTES-1-i) +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode and same-cycle transmit strobes.
  always_comb begin
    next_state = state;
    tx_go      = 1'b0;
    tx_byte    = 8'h00;
    mc_next    = 1'b0;
    cnt_inc    = 1'b0;
    last_byte  = 1'b0;
    err_evt    = 1'b0;
    desync_evt = 1'b0;
    if (!reset) begin
      if (timeout_hit) begin
        err_evt    = 1'b1;
        next_state = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.rxd_data_ready) begin
              case (bus.rxd_data)
                8'h01:   next_state = SET_HASH;
                8'h02:   next_state = PROC_LEN;
                8'h03:   next_state = RET_POS;
                8'h04:   next_state = TEST;
                8'h05:   next_state = STR_LEN;
                8'h06: begin
                  desync_evt = 1'b1;
                  next_state = ACK;
                end
                8'h07:   next_state = STATUS;
                default: err_evt = 1'b1;
              endcase
            end
          end
          SET_HASH: if (rx_acc) begin
            cnt_inc = 1'b1;
            if (cnt_plus1 == CW'(HASH_BYTES)) begin
              last_byte  = 1'b1;
              next_state = ACK;
            end
          end
          PROC_LEN: if (rx_acc) begin
            cnt_inc = 1'b1;
            if (cnt_plus1 == CW'(CNT_BYTES)) begin
              last_byte  = 1'b1;
              next_state = (len_shift == '0) ? PROC_WAIT : PROC_DATA;
            end
          end
          PROC_DATA: if (rx_acc) begin
            cnt_inc = 1'b1;
            if (cnt_plus1 == CW'(num_bytes_q)) begin
              last_byte  = 1'b1;
              next_state = PROC_WAIT;
            end
          end
          PROC_WAIT: if (bus.proc_done) next_state = ACK;
          RET_POS: if (bus.txd_ready_next) begin
            tx_go   = 1'b1;
            tx_byte = pos_byte;
            cnt_inc = 1'b1;
            if (cnt_plus1 == CW'(CNT_BYTES)) next_state = (str_bytes == '0) ? ACK : RET_STR;
          end
          RET_STR: if (bus.txd_ready_next) begin
            tx_go   = 1'b1;
            tx_byte = bus.proc_match_char;
            mc_next = 1'b1;
            cnt_inc = 1'b1;
            if (cnt_plus1 == str_bytes) next_state = ACK;
          end
          TEST: if (bus.txd_ready_next) begin
            tx_go   = 1'b1;
            tx_byte = TEST_START - byte_cnt[7:0];
            cnt_inc = 1'b1;
            if (cnt_plus1 == CW'(TEST_COUNT)) next_state = ACK;
          end
          STR_LEN: if (rx_acc) begin
            cnt_inc = 1'b1;
            if (cnt_plus1 == CW'(2)) begin
              last_byte  = 1'b1;
              next_state = ACK;
            end
          end
          STATUS: if (bus.txd_ready_next) begin
            tx_go      = 1'b1;
            tx_byte    = {6'b0, err_sticky, cmd_match_q};
            next_state = ACK;
          end
          ACK:     next_state = IDLE;
          default: next_state = IDLE;
        endcase
      end
    end
  end

  // Byte counter restarts on every state change; timer restarts on entry and on each received byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= '0;
      timer    <= '0;
    end else begin
      if (state != next_state) byte_cnt <= '0;
      else if (cnt_inc)        byte_cnt <= cnt_plus1;
      if (!in_rx || (state != next_state) || bus.rxd_data_ready) timer <= '0;
      else                                                       timer <= timer + TW'(1);
    end
  end

  // Field capture, payload streaming, result and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      hash_shadow       <= '0;
      target_hash_q     <= '0;
      len_shadow        <= '0;
      num_bytes_q       <= '0;
      str_shadow        <= '0;
      str_len_q         <= STR_LEN_RST;
      proc_data_q       <= 8'h00;
      proc_data_valid_q <= 1'b0;
      proc_start_q      <= 1'b0;
      cmd_match_q       <= 1'b0;
      cmd_error_q       <= 1'b0;
      desync_q          <= 1'b0;
      err_sticky        <= 1'b0;
    end else begin
      proc_start_q      <= 1'b0;
      proc_data_valid_q <= 1'b0;
      cmd_error_q       <= err_evt;
      desync_q          <= desync_evt;
      if (rx_acc) begin
        case (state)
          SET_HASH: begin
            hash_shadow <= hash_shift;
            if (last_byte) target_hash_q <= hash_shift;
          end
          PROC_LEN: begin
            len_shadow <= len_shift;
            if (last_byte) begin
              num_bytes_q  <= len_shift;
              proc_start_q <= 1'b1;
            end
          end
          PROC_DATA: begin
            proc_data_q       <= bus.rxd_data;
            proc_data_valid_q <= 1'b1;
          end
          STR_LEN: begin
            str_shadow <= str_shift;
            if (last_byte) str_len_q <= str_shift;
          end
          default: ;
        endcase
      end
      if ((state == PROC_WAIT) && bus.proc_done) cmd_match_q <= bus.proc_match;
      if (err_evt)                               err_sticky <= 1'b1;
      else if ((state == STATUS) && tx_go)       err_sticky <= 1'b0;
    end
  end

  assign led_ext = {{NUM_LEDS{1'b0}}, state};

  assign bus.txd_start            = tx_go;
  assign bus.txd_data             = tx_byte;
  assign bus.proc_match_char_next = mc_next;
  assign bus.proc_start           = proc_start_q;
  assign bus.proc_num_bytes       = num_bytes_q;
  assign bus.proc_data            = proc_data_q;
  assign bus.proc_data_valid      = proc_data_valid_q;
  assign bus.proc_target_hash     = target_hash_q;
  assign bus.proc_str_len         = str_len_q;
  assign bus.cmd_done             = (state == ACK) && !reset;
  assign bus.cmd_match            = cmd_match_q;
  assign bus.cmd_error            = cmd_error_q;
  assign bus.desync               = desync_q;
  assign bus.led                  = led_ext[NUM_LEDS-1:0];

endmodule

// File: tb/tb_cmd_parser_gen.sv
// Purpose: directed self-checking bench for cmd_parser_gen.
// Latency: events are logged at the falling edge and compared against hand-computed values.
// Backpressure: txd_ready_next is driven toggling, held high, or low depending on the test.
module tb_cmd_parser_gen;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cmd_parser_gen_if #(.NUM_LEDS(8), .HASH_BYTES(16), .CNT_BYTES(2)) bus ();

  cmd_parser_gen #(
    .NUM_LEDS(8), .HASH_BYTES(16), .CNT_BYTES(2), .TEST_COUNT(10),
    .TIMEOUT_CYCLES(50), .STR_LEN_RST(16'd152)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [127:0] HASH_A = 128'h000102030405060708090a0b0c0d0e0f;

  int n_chk = 0, n_pass = 0;
  int n_done = 0, n_err = 0, n_desync = 0, n_pstart = 0, n_mcn = 0, n_txviol = 0;
  logic [7:0] tx_log[$];
  logic [7:0] pd_log[$];
  logic [7:0] mc_idx = 8'h00;

  // Matched-string source: 'A','B','C',... advancing on proc_match_char_next.
  assign bus.proc_match_char = 8'h41 + mc_idx;
  always @(posedge clk) if (bus.proc_match_char_next) mc_idx <= mc_idx + 8'h01;

  // Event logger, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.cmd_done)             n_done++;
    if (bus.cmd_error)            n_err++;
    if (bus.desync)               n_desync++;
    if (bus.proc_start)           n_pstart++;
    if (bus.proc_match_char_next) n_mcn++;
    if (bus.txd_start && !bus.txd_ready_next) n_txviol++;
    if (bus.txd_start)            tx_log.push_back(bus.txd_data);
    if (bus.proc_data_valid)      pd_log.push_back(bus.proc_data);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] log_at(input logic [7:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 8'hEE;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rxd_data       = b;
    bus.rxd_data_ready = 1'b1;
    tick();
    bus.rxd_data_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    for (int i = 0; i < budget && n_done == d0; i++) tick();
    chk(tag, n_done - d0, 1);
  endtask

  int d0, e0, p0, q0, t0, m0, w;

  initial begin
    bus.rxd_data = 8'h00; bus.rxd_data_ready = 1'b0; bus.txd_ready_next = 1'b0;
    bus.proc_done = 1'b0; bus.proc_match = 1'b0; bus.proc_byte_pos = 16'h0000;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();

    // Reset / idle state.
    chk("rst_str_len", bus.proc_str_len, 16'h0098);
    chk("rst_led", bus.led, 8'h00);
    chk("rst_hash", bus.proc_target_hash, 128'h0);
    chk("rst_strobes", {bus.txd_start, bus.proc_start, bus.proc_data_valid, bus.proc_match_char_next,
                        bus.cmd_done, bus.cmd_match, bus.cmd_error, bus.desync}, 8'h00);
    chk("rst_num_bytes", bus.proc_num_bytes, 16'h0000);
    chk("rst_events", n_done + n_err + n_desync + n_pstart + tx_log.size() + pd_log.size(), 0);

    // SET_HASH with 0x00..0x0F.
    d0 = n_done;
    send_byte(8'h01);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    wait_done("hash_done", d0, 10);
    chk("hash_value", bus.proc_target_hash, HASH_A);
    repeat (3) tick();
    chk("hash_single_done", n_done - d0, 1);

    // proc_done outside PROC_WAIT must be ignored.
    d0 = n_done;
    bus.proc_match = 1'b1; bus.proc_done = 1'b1; tick();
    bus.proc_done = 1'b0; repeat (2) tick();
    chk("stray_done_match", bus.cmd_match, 1'b0);
    chk("stray_done_nodone", n_done - d0, 0);

    // PROC with three payload bytes.
    d0 = n_done; p0 = n_pstart; q0 = pd_log.size();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    repeat (5) tick();
    chk("proc_wait_nodone", n_done - d0, 0);
    chk("proc_num_bytes", bus.proc_num_bytes, 16'h0003);
    chk("proc_start_cnt", n_pstart - p0, 1);
    chk("proc_data_cnt", pd_log.size() - q0, 3);
    chk("proc_data_bytes", {log_at(pd_log, q0), log_at(pd_log, q0 + 1), log_at(pd_log, q0 + 2)}, 24'h616263);
    bus.proc_match = 1'b1; bus.proc_done = 1'b1; tick();
    bus.proc_done = 1'b0;
    wait_done("proc_done", d0, 10);
    chk("proc_match", bus.cmd_match, 1'b1);

    // STR_LEN = 0x0018 (3 chars).
    d0 = n_done;
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h18);
    wait_done("strlen_done", d0, 10);
    chk("strlen_value", bus.proc_str_len, 16'h0018);

    // RET with toggling txd_ready_next.
    bus.proc_byte_pos = 16'h1234;
    d0 = n_done; t0 = tx_log.size(); m0 = n_mcn;
    send_byte(8'h03);
    for (int i = 0; i < 40 && n_done == d0; i++) begin
      bus.txd_ready_next = (i % 2 == 0);
      tick();
    end
    bus.txd_ready_next = 1'b0;
    chk("ret_done", n_done - d0, 1);
    chk("ret_tx_cnt", tx_log.size() - t0, 5);
    chk("ret_tx_bytes", {log_at(tx_log, t0), log_at(tx_log, t0 + 1), log_at(tx_log, t0 + 2),
                         log_at(tx_log, t0 + 3), log_at(tx_log, t0 + 4)}, 40'h1234414243);
    chk("ret_mc_next", n_mcn - m0, 3);

    // PROC with zero length, no match.
    d0 = n_done; p0 = n_pstart; q0 = pd_log.size();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    repeat (2) tick();
    chk("proc0_start", n_pstart - p0, 1);
    chk("proc0_nodata", pd_log.size() - q0, 0);
    bus.proc_match = 1'b0; bus.proc_done = 1'b1; tick();
    bus.proc_done = 1'b0;
    wait_done("proc0_done", d0, 10);
    chk("proc0_match", bus.cmd_match, 1'b0);

    // Timeout mid SET_HASH.
    d0 = n_done; e0 = n_err;
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(8'hF0 + 8'(i));
    w = 0;
    while (w < 80 && n_err == e0) begin tick(); w++; end
    chk("timeout_err", n_err - e0, 1);
    chk("timeout_window", (w >= 48 && w <= 53), 1'b1);
    chk("timeout_nodone", n_done - d0, 0);
    chk("timeout_hash", bus.proc_target_hash, HASH_A);
    chk("timeout_led", bus.led, 8'h00);

    // STATUS reports err_sticky, then clears it.
    d0 = n_done; t0 = tx_log.size();
    bus.txd_ready_next = 1'b1;
    send_byte(8'h07);
    wait_done("status1_done", d0, 10);
    chk("status1_byte", log_at(tx_log, t0), 8'h02);
    d0 = n_done; t0 = tx_log.size();
    send_byte(8'h07);
    wait_done("status2_done", d0, 10);
    bus.txd_ready_next = 1'b0;
    chk("status2_byte", log_at(tx_log, t0), 8'h00);

    // Unknown command.
    d0 = n_done; e0 = n_err;
    send_byte(8'hAA);
    repeat (3) tick();
    chk("badcmd_err", n_err - e0, 1);
    chk("badcmd_nodone", n_done - d0, 0);

    // TEST with txd_ready_next held high.
    d0 = n_done; t0 = tx_log.size();
    bus.txd_ready_next = 1'b1;
    send_byte(8'h04);
    wait_done("test_done", d0, 30);
    bus.txd_ready_next = 1'b0;
    chk("test_tx_cnt", tx_log.size() - t0, 10);
    for (int i = 0; i < 10; i++) chk("test_byte", log_at(tx_log, t0 + i), 8'(10 - i));

    // CLOSE / desync.
    d0 = n_done; e0 = n_desync;
    send_byte(8'h06);
    wait_done("desync_done", d0, 10);
    chk("desync_cnt", n_desync - e0, 1);

    // Reset in the middle of TEST.
    bus.txd_ready_next = 1'b1;
    send_byte(8'h04);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_txd", bus.txd_start, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_led", bus.led, 8'h00);
    chk("rst_mid_txd2", bus.txd_start, 1'b0);
    chk("rst_mid_state", {bus.proc_str_len, bus.cmd_match, bus.cmd_done}, {16'h0098, 1'b0, 1'b0});
    chk("rst_mid_hash", bus.proc_target_hash, 128'h0);
    bus.txd_ready_next = 1'b0;
    tick();
    chk("tx_ready_rule", n_txviol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
